// File: rtl/regs_sha256.sv
// rtl/regs_sha256.sv - bus register block with embedded SHA-256 compression engine
//
// Software enables the block, pulses RESET, then pushes pre-padded 512-bit blocks
// as 32-bit words through the FIFO register; each full block is compressed in
// 64 single-cycle rounds and the running digest is readable at 0x120..0x13C.
//
// Ports:
//   clk_100mhz    system clock
//   rstn_i        asynchronous active-low reset
//   x11_activated block enable (CTRL bit0)
//   sys_addr      byte address, bits [19:0] decoded
//   sys_wdata     write data
//   sys_sel       byte selects (unused, full-word writes)
//   sys_wen       write strobe
//   sys_ren       read strobe
//   sys_rdata     registered read data, valid with sys_ack
//   sys_err       tied 0
//   sys_ack       acknowledge, one cycle after any strobe
//
// Optional: define SHA256_FIFO_COUNT_EN to expose the buffered word count in STATUS[12:8].
module regs_sha256 (
  input  logic        clk_100mhz,
  input  logic        rstn_i,
  output logic        x11_activated,
  input  logic [31:0] sys_addr,
  input  logic [31:0] sys_wdata,
  input  logic [3:0]  sys_sel,
  input  logic        sys_wen,
  input  logic        sys_ren,
  output logic [31:0] sys_rdata,
  output logic        sys_err,
  output logic        sys_ack
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_FINAL} state_t;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t      state, state_nxt;
  logic        ctrl_en, sha_rst, hash_valid, ovf;
  logic [4:0]  wcnt;
  logic [5:0]  rnd;
  logic [31:0] blkcnt;
  logic [31:0] fifo_buf [0:15];
  logic [31:0] w [0:15];
  logic [31:0] h [0:7];
  logic [31:0] v [0:7];
  logic [31:0] t1, t2, w_new, status, rd_mux;
  logic [3:0]  slot;
  logic        unused_bits;

  assign unused_bits   = ^{sys_sel, sys_addr[31:20]};
  assign x11_activated = ctrl_en;
  assign sys_err       = 1'b0;

  // Disabled behaves exactly like a held RESET.
  logic hold, buf_full, fifo_wr, start, accept, drop;
  assign hold     = sha_rst | ~ctrl_en;
  assign buf_full = (wcnt == 5'd16);
  assign fifo_wr  = sys_wen & ctrl_en & (sys_addr[19:0] == 20'h0010C);
  assign start    = (state == S_IDLE) & buf_full & ~hold;
  // A write coinciding with start lands in the freshly emptied slot 0.
  assign accept   = fifo_wr & ~hold & (~buf_full | start);
  assign drop     = fifo_wr & ~hold & buf_full & ~start;
  assign slot     = start ? 4'd0 : wcnt[3:0];

  always_comb begin
    state_nxt = state;
    if (hold) state_nxt = S_IDLE;
    else begin
      case (state)
        S_IDLE:  if (buf_full) state_nxt = S_LOAD;
        S_LOAD:  state_nxt = S_ROUND;
        S_ROUND: if (rnd == 6'd63) state_nxt = S_FINAL;
        S_FINAL: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // One compression round plus the next schedule word from the sliding window w[t..t+15].
  always_comb begin
    t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[rnd] + w[0];
    t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
            + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
  end

  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= S_IDLE;
      ctrl_en <= 1'b0; sha_rst <= 1'b0; hash_valid <= 1'b0; ovf <= 1'b0;
      wcnt <= '0; rnd <= '0; blkcnt <= '0;
      for (int i = 0; i < 16; i++) begin fifo_buf[i] <= '0; w[i] <= '0; end
      for (int i = 0; i < 8; i++) begin h[i] <= IV[i]; v[i] <= '0; end
    end else begin
      state <= state_nxt;
      if (sys_wen && sys_addr[19:0] == 20'h00000) ctrl_en <= sys_wdata[0];
      if (sys_wen && ctrl_en && sys_addr[19:0] == 20'h00100) sha_rst <= sys_wdata[0];
      if (hold) begin
        wcnt <= '0; hash_valid <= 1'b0; ovf <= 1'b0;
        for (int i = 0; i < 8; i++) h[i] <= IV[i];
      end else begin
        // Write pairs form {second,first}: first write fills the odd W slot.
        if (accept) fifo_buf[{slot[3:1], ~slot[0]}] <= sys_wdata;
        if (start) wcnt <= accept ? 5'd1 : 5'd0;
        else if (accept) wcnt <= wcnt + 5'd1;
        if (drop) ovf <= 1'b1;
        if (start) begin
          for (int i = 0; i < 16; i++) w[i] <= fifo_buf[i];
          hash_valid <= 1'b0;
        end
        case (state)
          S_LOAD: begin
            for (int i = 0; i < 8; i++) v[i] <= h[i];
            rnd <= '0;
          end
          S_ROUND: begin
            v[0] <= t1 + t2; v[1] <= v[0]; v[2] <= v[1]; v[3] <= v[2];
            v[4] <= v[3] + t1; v[5] <= v[4]; v[6] <= v[5]; v[7] <= v[6];
            for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
            w[15] <= w_new;
            rnd <= rnd + 6'd1;
          end
          S_FINAL: begin
            for (int i = 0; i < 8; i++) h[i] <= h[i] + v[i];
            hash_valid <= 1'b1;
            blkcnt <= blkcnt + 32'd1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    status    = '0;
    status[0] = ~hold & (state == S_IDLE) & ~buf_full;
    status[1] = hash_valid;
    status[2] = ~hold & ((state != S_IDLE) | buf_full);
    status[4] = ovf;
`ifdef SHA256_FIFO_COUNT_EN
    status[12:8] = wcnt;
`endif
  end

  always_comb begin
    rd_mux = '0;
    case (sys_addr[19:0])
      20'h00000: rd_mux = {31'd0, ctrl_en};
      20'h00100: rd_mux = {31'd0, sha_rst};
      20'h00104: rd_mux = status;
      20'h00110: rd_mux = blkcnt;
      default:
        if (sys_addr[19:5] == 15'h0009 && sys_addr[1:0] == 2'b00) rd_mux = h[sys_addr[4:2]];
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      sys_ack   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      sys_ack   <= sys_wen | sys_ren;
      sys_rdata <= sys_ren ? rd_mux : 32'd0;
    end
  end
endmodule

// File: tb/tb_regs_sha256.sv
// tb/tb_regs_sha256.sv - randomized self-checking bench for regs_sha256 against a SHA-256 reference model
module tb_regs_sha256;
  logic        clk_100mhz = 1'b0;
  logic        rstn_i = 1'b0;
  logic        x11_activated;
  logic [31:0] sys_addr = '0;
  logic [31:0] sys_wdata = '0;
  logic [3:0]  sys_sel = '0;
  logic        sys_wen = 1'b0;
  logic        sys_ren = 1'b0;
  logic [31:0] sys_rdata;
  logic        sys_err;
  logic        sys_ack;

  regs_sha256 dut (
    .clk_100mhz(clk_100mhz), .rstn_i(rstn_i), .x11_activated(x11_activated),
    .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_sel(sys_sel),
    .sys_wen(sys_wen), .sys_ren(sys_ren), .sys_rdata(sys_rdata),
    .sys_err(sys_err), .sys_ack(sys_ack));

  always #5 clk_100mhz = ~clk_100mhz;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] KT [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [31:0] IV_T [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] DIGEST_A [0:7] = '{
    32'h559aead0, 32'h8264d579, 32'h5d390971, 32'h8cdd05ab,
    32'hd49572e8, 32'h4fe55590, 32'heef31a88, 32'ha08fdffd};

  logic [31:0] mh [0:7];
  logic [31:0] exp_blkcnt;
  logic [31:0] words [0:63];
  logic [31:0] rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Full-schedule textbook compression of words[base..base+15], given in bus write order.
  task automatic model_compress(input int base);
    logic [31:0] m [0:63];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int k = 0; k < 8; k++) begin
      m[2*k]   = words[base + 2*k + 1];
      m[2*k+1] = words[base + 2*k];
    end
    for (int t = 16; t < 64; t++)
      m[t] = (ror(m[t-2], 17) ^ ror(m[t-2], 19) ^ (m[t-2] >> 10)) + m[t-7]
             + (ror(m[t-15], 7) ^ ror(m[t-15], 18) ^ (m[t-15] >> 3)) + m[t-16];
    a = mh[0]; b = mh[1]; c = mh[2]; d = mh[3]; e = mh[4]; f = mh[5]; g = mh[6]; hh = mh[7];
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + m[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    mh[0] += a; mh[1] += b; mh[2] += c; mh[3] += d;
    mh[4] += e; mh[5] += f; mh[6] += g; mh[7] += hh;
    exp_blkcnt++;
  endtask

  task automatic model_iv();
    for (int i = 0; i < 8; i++) mh[i] = IV_T[i];
  endtask

  task automatic bus_write(input logic [19:0] a, input logic [31:0] d);
    @(negedge clk_100mhz);
    sys_addr = {12'($urandom), a}; sys_wdata = d; sys_sel = 4'($urandom); sys_wen = 1'b1;
    @(negedge clk_100mhz);
    sys_wen = 1'b0;
    check("wr_ack", {31'd0, sys_ack}, 32'd1);
  endtask

  task automatic bus_read(input logic [19:0] a, output logic [31:0] d);
    @(negedge clk_100mhz);
    sys_addr = {12'($urandom), a}; sys_ren = 1'b1;
    @(negedge clk_100mhz);
    sys_ren = 1'b0;
    check("rd_ack", {31'd0, sys_ack}, 32'd1);
    d = sys_rdata;
  endtask

  task automatic push_words(input int base, input int n);
    for (int i = 0; i < n; i++) bus_write(20'h0010C, words[base + i]);
  endtask

  task automatic check_hash(input string tag);
    for (int i = 0; i < 8; i++) begin
      bus_read(20'h00120 + 20'(4 * i), rd);
      check(tag, rd, mh[i]);
    end
  endtask

  task automatic pulse_reset();
    bus_write(20'h00100, 32'd1);
    bus_write(20'h00100, 32'd0);
  endtask

  initial begin
    model_iv();
    exp_blkcnt = '0;
    repeat (3) @(negedge clk_100mhz);
    check("rst_x11", {31'd0, x11_activated}, 32'd0);
    check("rst_ack", {31'd0, sys_ack}, 32'd0);
    check("rst_rdata", sys_rdata, 32'd0);
    rstn_i = 1'b1;
    bus_read(20'h00104, rd); check("rst_status", rd, 32'd0);
    bus_read(20'h00110, rd); check("rst_blkcnt", rd, 32'd0);
    bus_read(20'h00120, rd); check("rst_h0", rd, 32'h6a09e667);

    // Known-answer block: SHA-256("A").
    bus_write(20'h00000, 32'd1);
    check("en_x11", {31'd0, x11_activated}, 32'd1);
    pulse_reset();
    bus_read(20'h00104, rd); check("status_ready", rd, 32'd1);
    for (int i = 0; i < 16; i++) words[i] = 32'd0;
    words[1] = 32'h41800000; words[14] = 32'h00000008;
    push_words(0, 16);
    bus_read(20'h00104, rd);
    check("kat_busy", {31'd0, rd[2]}, 32'd1);
    check("kat_ovf", {31'd0, rd[4]}, 32'd0);
    repeat (115) @(negedge clk_100mhz);
    bus_read(20'h00104, rd); check("kat_valid", {31'd0, rd[1]}, 32'd1);
    bus_read(20'h00110, rd); check("kat_blkcnt", rd, 32'd1);
    for (int i = 0; i < 8; i++) begin
      bus_read(20'h00120 + 20'(4 * i), rd);
      check("kat_hash", rd, DIGEST_A[i]);
    end
    model_compress(0);

    // Random chained blocks.
    for (int blk = 0; blk < 3; blk++) begin
      for (int i = 0; i < 16; i++) words[i] = $urandom;
      push_words(0, 16);
      model_compress(0);
      repeat (80) @(negedge clk_100mhz);
      bus_read(20'h00104, rd); check("rnd_status", rd, 32'h3);
      bus_read(20'h00110, rd); check("rnd_blkcnt", rd, exp_blkcnt);
      check_hash("rnd_hash");
    end

    pulse_reset();
    model_iv();
    bus_read(20'h00104, rd); check("reset_status", rd, 32'h1);
    bus_read(20'h00120, rd); check("reset_h0", rd, 32'h6a09e667);

    // 33 back-to-back words: 16 compressing, 16 buffered, the 33rd dropped.
    for (int i = 0; i < 33; i++) words[i] = $urandom;
    push_words(0, 33);
    bus_read(20'h00104, rd);
    check("ovf_bit", {31'd0, rd[4]}, 32'd1);
    check("ovf_busy", {31'd0, rd[2]}, 32'd1);
    model_compress(0);
    model_compress(16);
    repeat (160) @(negedge clk_100mhz);
    bus_read(20'h00104, rd); check("ovf_status", rd, 32'h13);
    bus_read(20'h00110, rd); check("ovf_blkcnt", rd, exp_blkcnt);
    check_hash("ovf_hash");

    // Disabled: block-register writes ignored, engine held.
    bus_write(20'h00000, 32'd0);
    check("dis_x11", {31'd0, x11_activated}, 32'd0);
    bus_read(20'h00104, rd); check("dis_status", rd, 32'd0);
    bus_write(20'h00100, 32'd1);
    bus_read(20'h00100, rd); check("dis_rst_ign", rd, 32'd0);
    for (int i = 0; i < 16; i++) words[i] = $urandom;
    push_words(0, 16);
    model_iv();
    bus_write(20'h00000, 32'd1);
    repeat (80) @(negedge clk_100mhz);
    bus_read(20'h00104, rd); check("reen_status", rd, 32'h1);
    bus_read(20'h00110, rd); check("reen_blkcnt", rd, exp_blkcnt);
    check_hash("reen_hash");

    // Unmapped address and write-only FIFO readback.
    bus_read(20'h00400, rd);
    check("unmap_rdata", rd, 32'd0);
    check("unmap_err", {31'd0, sys_err}, 32'd0);
    bus_write(20'h00400, $urandom);
    bus_read(20'h0010C, rd); check("fifo_rd0", rd, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
